add_seq_ctrl: RTL and testbench

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

---
 rtl/add_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_add_seq_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: nibble-serial adder/subtractor with valid/ready handshake.
// One 4-bit full-adder slice is reused once per nibble, LSB nibble first;
// the result is presented in DONE until the consumer accepts it.
module add_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  // Shared 4-bit slice operating on nibble k
  logic [3:0]    a_nib, b_nib;
  logic [4:0]    slice;
  logic          c_into_msb;

  // Select the current nibble and add it with the running carry
  always_comb begin
    a_nib      = a_q[{k_q, 2'b00} +: 4];
    b_nib      = b_q[{k_q, 2'b00} +: 4];
    slice      = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    // carry into bit 3 recovered from its sum bit and the two operand bits
    c_into_msb = a_nib[3] ^ b_nib[3] ^ slice[3];
  end

  // Next-state and datapath update; ena low holds everything
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    k_d     = k_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_d     = op_a;
            b_d     = sub ? ~op_b : op_b;
            carry_d = sub ? 1'b1 : cin;
            k_d     = '0;
            sum_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          sum_d[{k_q, 2'b00} +: 4] = slice[3:0];
          carry_d = slice[4];
          if (k_q == K_LAST) begin
            k_d     = '0;
            cout_d  = slice[4];
            ovf_d   = c_into_msb ^ slice[4];
            state_d = DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake and status outputs decoded from the state register
  always_comb begin
    in_ready  = (state_q == IDLE) && ena;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed testbench for add_seq_ctrl (NIBBLES = 4).
module tb_add_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, ena, in_valid, in_ready, cin, sub;
  logic        out_valid, out_ready, cout, ovf, busy;
  logic [15:0] op_a, op_b, sum;

  int checks = 0;
  int errors = 0;

  add_seq_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for out_valid after an accepting edge; returns edges counted
  task automatic wait_valid(output int edges);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 30) begin
      @(posedge clk); #1;
      edges++;
    end
    if (out_valid !== 1'b1) chk("timeout_out_valid", 0, 1);
  endtask

  // Full transaction: accept, scramble inputs during RUN, check result, handshake
  task automatic do_op(input vec_t v, input string name);
    int edges;
    @(negedge clk);
    in_valid = 1'b1; op_a = v.a; op_b = v.b; cin = v.ci; sub = v.sb;
    out_ready = 1'b0;
    #1 chk({name, "_in_ready"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = ~v.a; op_b = 16'h5A5A; cin = ~v.ci; sub = ~v.sb;
    chk({name, "_busy"}, 32'(busy), 1);
    wait_valid(edges);
    chk({name, "_latency"}, 32'(edges), 4);
    chk({name, "_sum"}, 32'(sum), 32'(v.exp_sum));
    chk({name, "_cout"}, 32'(cout), 32'(v.exp_cout));
    chk({name, "_ovf"}, 32'(ovf), 32'(v.exp_ovf));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, "_valid_drop"}, 32'(out_valid), 0);
    chk({name, "_ready_back"}, 32'(in_ready), 1);
    chk({name, "_sum_retained"}, 32'(sum), 32'(v.exp_sum));
    out_ready = 1'b0;
  endtask

  initial begin
    int edges;
    logic [15:0] held;

    vecs[0] = '{16'h1234, 16'h0FCC, 1'b0, 1'b0, 16'h2200, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_in_ready_ena0", 32'(in_ready), 0);
    ena = 1'b1;
    #1 chk("rst_in_ready_ena1", 32'(in_ready), 1);

    for (int i = 0; i < 6; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure with in_valid held high throughout
    @(negedge clk);
    in_valid = 1'b1; op_a = 16'h1234; op_b = 16'h0FCC; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    op_a = 16'hFFFF; op_b = 16'h0001;
    wait_valid(edges);
    chk("bp_latency", 32'(edges), 4);
    held = sum;
    chk("bp_sum", 32'(held), 32'h2200);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_valid%0d", c), 32'(out_valid), 1);
      chk($sformatf("bp_hold_sum%0d", c), 32'(sum), 32'(held));
      chk($sformatf("bp_hold_ready%0d", c), 32'(in_ready), 0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_no_reaccept_busy", 32'(busy), 0);
    chk("bp_in_ready_after", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accept", 32'(busy), 1);
    wait_valid(edges);
    chk("bp2_latency", 32'(edges), 4);
    chk("bp2_sum", 32'(sum), 32'h0000);
    chk("bp2_cout", 32'(cout), 1);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Enable stall for two edges mid-RUN while op_a changes
    @(negedge clk);
    in_valid = 1'b1; op_a = 16'h1234; op_b = 16'h0FCC; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (out_valid !== 1'b1 && edges < 30) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 2) begin ena = 1'b0; op_a = 16'hAAAA; end
      if (edges == 4) begin
        chk("stall_busy", 32'(busy), 1);
        ena = 1'b1;
      end
    end
    chk("stall_latency", 32'(edges), 6);
    chk("stall_sum", 32'(sum), 32'h2200);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Reset mid-RUN aborts the operation
    @(negedge clk);
    in_valid = 1'b1; op_a = 16'h1234; op_b = 16'h0FCC;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rr_out_valid", 32'(out_valid), 0);
    chk("rr_sum", 32'(sum), 0);
    chk("rr_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rr_in_ready", 32'(in_ready), 1);
    do_op(vecs[2], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
